// File: rtl/corelet_pkg.sv
// Shared definitions for the corelet back-end: sequencer state encoding and
// the PMEM layout constants used by the psum read-back path.
package corelet_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READ  = 3'd1,
        ST_ACC   = 3'd2,
        ST_WRITE = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    localparam int KIJ_NUM     = 9;
    localparam int NIJ_PER_KIJ = 36;
    localparam int OUT_BASE    = 324;
    localparam int OUT_PIX     = 16;
    localparam int ADDR_W      = 9;
    localparam int ACC_GUARD   = 4;

endpackage

// File: rtl/psum_lane_acc.sv
// One output lane: widened signed accumulator with clear/add, followed by
// saturation back to psum_bw and an optional ReLU.
module psum_lane_acc
    import corelet_pkg::*;
#(
    parameter int psum_bw = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clr,
    input  logic               add,
    input  logic               relu_en,
    input  logic [psum_bw-1:0] din,
    output logic [psum_bw-1:0] dout
);

    localparam int ACC_W = psum_bw + ACC_GUARD;
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((1 << (psum_bw - 1)) - 1);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

    logic signed [ACC_W-1:0] acc_q;
    logic signed [ACC_W-1:0] acc_d;
    logic signed [ACC_W-1:0] sat;

    always_comb begin
        acc_d = acc_q;
        if (clr) begin
            acc_d = '0;
        end else if (add) begin
            acc_d = acc_q + ACC_W'(signed'(din));
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    always_comb begin
        sat = acc_q;
        if (acc_q > SAT_MAX) begin
            sat = SAT_MAX;
        end else if (acc_q < SAT_MIN) begin
            sat = SAT_MIN;
        end
        dout = sat[psum_bw-1:0];
        if (relu_en && (sat < 0)) begin
            dout = '0;
        end
    end

endmodule

// File: rtl/psum_accumulator.sv
// Reads back the 9 kij partial sums of every output pixel from PMEM, sums them
// lane-wise and writes the saturated (optionally ReLU'd) result to the output region.
//
// state | meaning
// IDLE  | waiting for start, SRAM port released
// READ  | one psum read per cycle, k = 0..kij_num-1
// ACC   | last read's data lands in the accumulators
// WRITE | final word written at out_base + o
// DONE  | one-cycle done pulse
module psum_accumulator
    import corelet_pkg::*;
#(
    parameter int col     = 8,
    parameter int psum_bw = 16,
    parameter int kij_num = KIJ_NUM,
    parameter int a_dim   = 6,
    parameter int o_dim   = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     relu_en,
    output logic                     busy,
    output logic                     done,
    input  logic [col*psum_bw-1:0]   OP_q,
    output logic [col*psum_bw-1:0]   OP_d,
    output logic [ADDR_W-1:0]        OP_addr,
    output logic                     OP_cen,
    output logic                     OP_wen
);

    localparam int NIJ   = a_dim * a_dim;
    localparam int PIX   = o_dim * o_dim;
    localparam int K_DIM = a_dim - o_dim + 1;
    localparam int OBASE = kij_num * NIJ;
    localparam int O_W   = $clog2(PIX);
    localparam int K_W   = $clog2(kij_num);

    state_e           state_q, state_d;
    logic [O_W-1:0]   o_q, o_d;
    logic [K_W-1:0]   k_q, k_d;
    logic             relu_q, relu_d;
    logic             rd_valid_q, rd_valid_d;
    logic             acc_clr;

    logic [ADDR_W-1:0] o_ext, k_ext, orow, ocol, ki, kj, rd_addr, wr_addr;
    logic [col*psum_bw-1:0] lane_out;

    // Address of psum word (kij k, nij of pixel o under kernel offset ki/kj).
    always_comb begin
        o_ext   = ADDR_W'(o_q);
        k_ext   = ADDR_W'(k_q);
        orow    = o_ext / ADDR_W'(o_dim);
        ocol    = o_ext % ADDR_W'(o_dim);
        ki      = k_ext / ADDR_W'(K_DIM);
        kj      = k_ext % ADDR_W'(K_DIM);
        rd_addr = k_ext * ADDR_W'(NIJ) + (orow + ki) * ADDR_W'(a_dim) + (ocol + kj);
        wr_addr = ADDR_W'(OBASE) + o_ext;
    end

    always_comb begin
        state_d    = state_q;
        o_d        = o_q;
        k_d        = k_q;
        relu_d     = relu_q;
        rd_valid_d = (state_q == ST_READ);
        acc_clr    = 1'b0;
        busy       = (state_q != ST_IDLE);
        done       = 1'b0;
        OP_cen     = 1'b1;
        OP_wen     = 1'b1;
        OP_addr    = '0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_READ;
                    o_d     = '0;
                    k_d     = '0;
                    relu_d  = relu_en;
                    acc_clr = 1'b1;
                end
            end
            ST_READ: begin
                OP_cen  = 1'b0;
                OP_addr = rd_addr;
                if (k_q == K_W'(kij_num - 1)) begin
                    state_d = ST_ACC;
                end else begin
                    k_d = k_q + K_W'(1);
                end
            end
            ST_ACC: begin
                state_d = ST_WRITE;
            end
            ST_WRITE: begin
                OP_cen  = 1'b0;
                OP_wen  = 1'b0;
                OP_addr = wr_addr;
                acc_clr = 1'b1;
                if (o_q == O_W'(PIX - 1)) begin
                    state_d = ST_DONE;
                end else begin
                    o_d     = o_q + O_W'(1);
                    k_d     = '0;
                    state_d = ST_READ;
                end
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            o_q        <= '0;
            k_q        <= '0;
            relu_q     <= 1'b0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            o_q        <= o_d;
            k_q        <= k_d;
            relu_q     <= relu_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    for (genvar i = 0; i < col; i++) begin : g_lane
        psum_lane_acc #(
            .psum_bw (psum_bw)
        ) u_lane (
            .clk     (clk),
            .reset   (reset),
            .clr     (acc_clr),
            .add     (rd_valid_q),
            .relu_en (relu_q),
            .din     (OP_q[i*psum_bw +: psum_bw]),
            .dout    (lane_out[i*psum_bw +: psum_bw])
        );
    end

    assign OP_d = (state_q == ST_WRITE) ? lane_out : '0;

endmodule

// File: doc/psum_accumulator.md
# psum_accumulator

Reads back the partial sums that the corelet sequencer writes into the PSUM/output SRAM (PMEM): 9 kij passes × 36 nij words. For each of the 16 output pixels it fetches the 9 contributing psum words, accumulates them lane-wise, saturates, optionally applies ReLU, and writes the final word into the output region of the same SRAM. It sits beside the corelet and takes over the OP SRAM port after the corelet's sequence finishes.

## Interface
- `col`, default 8: output lanes per SRAM word.
- `psum_bw`, default 16: signed bits per lane.
- `kij_num`, default 9: kernel positions (3×3).
- `a_dim`, default 6: input feature-map side length; 36 nij words per kij block.
- `o_dim`, default 4: output side length; 16 output pixels.
- `clk`, in, 1: single clock, all state on its rising edge.
- `reset`, in, 1: asynchronous, active-low (asserted when 0).
- `start`, in, 1: begin a pass; sampled only in IDLE.
- `relu_en`, in, 1: captured on the cycle `start` is accepted.
- `busy`, out, 1: high in every state except IDLE.
- `done`, out, 1: one-cycle pulse at end of a pass.
- `OP_q`, in, col*psum_bw: SRAM read data, valid one cycle after a read.
- `OP_d`, out, col*psum_bw: SRAM write data.
- `OP_addr`, out, 9: SRAM address.
- `OP_cen`, out, 1: chip enable, active-low.
- `OP_wen`, out, 1: write enable, active-low (0 = write, 1 = read).

## Operation
- PMEM layout: psum for kij k, nij n at address k*36 + n (0..323). Final output for pixel o is written at 324 + o (324..339).
- Pixel o: orow = o/4, ocol = o%4. For kij k: ki = k/3, kj = k%3, nij = (orow+ki)*6 + (ocol+kj).
- State machine:
  - IDLE: on `start`, go to READ with o=0, k=0, acc=0.
  - READ: cen=0, wen=1, addr=k*36+nij(o,k). When k=8, go to ACC; otherwise k++.
  - ACC: cen=1. Absorbs the last read.
  - WRITE: cen=0, wen=0, addr=324+o, d=final word. If o=15, go to DONE; otherwise o++, k=0, acc=0, go to READ.
  - DONE: done=1, then go to IDLE.
- Accumulation: a registered read-valid flag marks the cycle after each read. In that cycle, acc[lane] += sign-extended OP_q lane.
- Accumulator width is psum_bw+4 = 20 bits signed per lane; no overflow is possible for 9 terms.
- Final lane value:
  - Saturate to psum_bw signed: >32767 → 32767, <−32768 → −32768.
  - Then, if relu_en is set, negative values → 0.
- Lane i occupies bits [16i+15:16i].

## Timing
- Reset values: busy=0, done=0, OP_cen=1, OP_wen=1, OP_addr=0, OP_d=0; state=IDLE; all counters and accumulators 0.
- Outputs are decoded from registered state and counters.
- One pixel takes 11 cycles: 9 READ + 1 ACC + 1 WRITE.
- Let `start` be accepted at edge E0. READ is active from E0, and DONE is entered at E0+176. `done` is high exactly one cycle; `busy` falls at E0+177.
- Every read is followed by its data on OP_q at the next edge; the block adds no extra latency.
- Exactly one write per pixel; 16 writes per pass; no writes to 0..323.
- `start` while busy is ignored. `start` held high through DONE restarts on the cycle after DONE, in IDLE.
- `reset` asserted mid-pass:
  - cen/wen go to 1 immediately (asynchronous) and state returns to IDLE.
  - The partially written output region is left as is.
  - No `done` is issued.
- `relu_en` changing mid-pass has no effect.

## Structure
- Shared `corelet_pkg`:
  - state enum (IDLE, READ, ACC, WRITE, DONE);
  - constants KIJ_NUM=9, NIJ_PER_KIJ=36, OUT_BASE=324, OUT_PIX=16.
- Sub-module `psum_lane_acc`, instantiated `col` times. Contents: clear/add, 20-bit accumulator, saturate and ReLU output.
- Top level holds the FSM, o/k counters and the address generator.

## Test plan
- Every PMEM word 0..323 has all lanes = 1, relu_en=0 → all words 324..339 have every lane = 9; `done` at start+177.
- PMEM word at address a has lane 0 = a → output 324 lane 0 = 0+1+2+6+7+8+12+13+14 + 36·(0+…+8) = 63+1296 = 1359. Also check the full read address sequence for pixel 0 and pixel 15; pixel 15 starts at address 21.
- All lanes = 30000 → output 32767 (positive saturation); all lanes = −30000 with relu_en=0 → −32768; same with relu_en=1 → 0.
- Mixed signs: lane 3 = −5 for kij 0..4 and +2 for kij 5..8 → −17; with relu_en=1 → 0.
- Assert `reset`=0 at cycle 50 of a pass → cen=1 that cycle, busy=0, no `done`. A fresh `start` then gives correct results at start+177.
- `start` pulsed at cycles 10 and 100 of a pass → ignored. `start` held high continuously → back-to-back passes, `done` every 178 cycles.
